keypad_scanner: RTL and testbench



---
 rtl/vm_keypad_pkg.sv | 67 ++++++
 rtl/keypad_scanner_row_sync.sv | 24 ++
 rtl/keypad_scanner.sv | 168 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_keypad_pkg.sv
// Shared types and constants for the vending-machine keypad path.
// Key map, column drive patterns and named key codes live here so that
// the scanner and downstream consumers agree on one encoding.
package vm_keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Named function keys
  localparam logic [3:0] KEY_OK     = 4'hF;
  localparam logic [3:0] KEY_CANCEL = 4'hE;
  localparam logic [3:0] KEY_TAKE   = 4'hD;

  // One-hot active-low column drive patterns, in scan order
  localparam logic [3:0] COL0 = 4'b1110;
  localparam logic [3:0] COL1 = 4'b1101;
  localparam logic [3:0] COL2 = 4'b1011;
  localparam logic [3:0] COL3 = 4'b0111;

  // Key map, entry {row_idx, col_idx} at bits [4*entry +: 4].
  // Rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
  localparam logic [63:0] KEY_MAP = {
    KEY_TAKE, KEY_OK, 4'h0, KEY_CANCEL,
    4'hC,     4'h9,   4'h8, 4'h7,
    4'hB,     4'h6,   4'h5, 4'h4,
    4'hA,     4'h3,   4'h2, 4'h1
  };

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    logic [3:0] drv;
    case (idx)
      2'd0:    drv = COL0;
      2'd1:    drv = COL1;
      2'd2:    drv = COL2;
      default: drv = COL3;
    endcase
    return drv;
  endfunction

  function automatic logic [3:0] key_lookup(input logic [1:0] row_idx,
                                            input logic [1:0] col_idx);
    return KEY_MAP[{row_idx, col_idx, 2'b00} +: 4];
  endfunction

  // True when exactly one row line is pulled low
  function automatic logic single_low(input logic [3:0] rows);
    return (rows == 4'b1110) || (rows == 4'b1101) ||
           (rows == 4'b1011) || (rows == 4'b0111);
  endfunction

  // Index of the low row line; only meaningful when single_low() holds
  function automatic logic [1:0] low_index(input logic [3:0] rows);
    logic [1:0] idx;
    case (rows)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// row_sync: 4-bit two-flop synchronizer for the asynchronous keypad rows.
// Flops reset to the idle (all pulled-up) level so no phantom key is seen
// while the chain refills after reset.
module row_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] row_s
);

  logic [3:0] row_meta;

  // Two-stage capture of the raw row lines into the clk domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta <= 4'hF;
      row_s    <= 4'hF;
    end else begin
      row_meta <= row;
      row_s    <= row_meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scanner with press/release debounce and
// multi-key rejection; emits one key_valid strobe per physical press.
// Optional auto-repeat while held: define KEYPAD_AUTOREPEAT_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// SCAN     | drive columns in turn, sample rows at end of each dwell
// DEBOUNCE | column frozen, counting stable single-key samples
// PRESSED  | key accepted and held, waiting for rows to go idle
// RELEASE  | rows idle, counting stable idle samples before rescanning
module keypad_scanner
  import vm_keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CYC = 1000,
  parameter int REPEAT_DELAY = 50000,
  parameter int REPEAT_CYC   = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] shift_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYC - 1);

  // Reject configurations the dwell/debounce/repeat logic cannot honour
  if (SCAN_DIV < 2 || DEBOUNCE_CYC < 1 || REPEAT_DELAY < 1 || REPEAT_CYC < 1) begin : g_bad_cfg
    $error("keypad_scanner: parameter below its minimum");
  end

  logic [3:0]    row_s;
  state_t        state;
  logic [1:0]    col_idx;
  logic [DW-1:0] dwell;
  logic [BW-1:0] deb_cnt;
  logic [3:0]    cand_pat;
  logic [1:0]    cand_row;
  logic [1:0]    cand_col;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_CYC) ? REPEAT_DELAY : REPEAT_CYC;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RC_LAST = RW'(REPEAT_CYC - 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_armed;   // first repeat already issued
`endif

  row_sync u_row_sync (
    .clk   (clk),
    .reset (reset),
    .row   (row),
    .row_s (row_s)
  );

  // Scan/debounce state machine with registered column drive and key outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      shift_col <= COL0;
      dwell     <= '0;
      deb_cnt   <= '0;
      cand_pat  <= 4'hF;
      cand_row  <= 2'd0;
      cand_col  <= 2'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (single_low(row_s)) begin
              cand_pat <= row_s;
              cand_row <= low_index(row_s);
              cand_col <= col_idx;
              deb_cnt  <= '0;
              state    <= DEBOUNCE;
            end else begin
              // idle or multi-key: move on to the next column
              col_idx   <= col_idx + 2'd1;
              shift_col <= col_drive(col_idx + 2'd1);
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (row_s == cand_pat) begin
            if (deb_cnt == DEB_LAST) begin
              key_code  <= key_lookup(cand_row, cand_col);
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              deb_cnt   <= '0;
              state     <= PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt   <= '0;
              rep_armed <= 1'b0;
`endif
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end else begin
            state     <= SCAN;
            col_idx   <= col_idx + 2'd1;
            shift_col <= col_drive(col_idx + 2'd1);
          end
        end

        PRESSED: begin
          if (row_s == 4'hF) begin
            deb_cnt <= '0;
            state   <= RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
          end else if (rep_cnt == (rep_armed ? RC_LAST : RD_LAST)) begin
            key_valid <= 1'b1;
            rep_cnt   <= '0;
            rep_armed <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
`endif
          end
        end

        RELEASE: begin
          if (row_s == 4'hF) begin
            if (deb_cnt == DEB_LAST) begin
              key_held  <= 1'b0;
              deb_cnt   <= '0;
              dwell     <= '0;
              state     <= SCAN;
              col_idx   <= col_idx + 2'd1;
              shift_col <= col_drive(col_idx + 2'd1);
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end else begin
            // contact bounce on release: still the same press
            deb_cnt <= '0;
            state   <= PRESSED;
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: a physical key-matrix model drives the rows
// from the scanner's column drive; expectations come from press-level rules
// (one event per held press, mapped code, bounded latency, held window).
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CYC = 8;
  localparam int REPEAT_DELAY = 40;
  localparam int REPEAT_CYC   = 20;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int HOLD_MAX = 45;
`else
  localparam int HOLD_MAX = 100;
`endif

  localparam logic [3:0] KMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };
  localparam logic [3:0] COLS [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row;
  logic [3:0]  shift_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = 16'h0;   // bit r*4+c = key (r,c) closed

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         ev_count = 0;
  int         ev_times[$];
  logic [3:0] ev_codes[$];
  int         fall_time = -1;
  int         kv_consec = 0;
  logic       prev_kv = 1'b0;
  logic       prev_held = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Matrix: a closed key pulls its row low while its column is driven low
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !shift_col[c]) row[r] = 1'b0;
  end

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_CYC   (REPEAT_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .shift_col (shift_col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Event recorder, sampled on the falling edge
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      if (prev_kv) kv_consec++;
      ev_count++;
      ev_times.push_back(cyc);
      ev_codes.push_back(key_code);
    end
    if (prev_held && !key_held) fall_time = cyc;
    prev_kv   = key_valid;
    prev_held = key_held;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One press: optional press bounce, stable hold, optional release bounce
  task automatic do_press(input int r, input int c, input int r2, input int pb,
                          input int bl, input int hold, input int rb, input bit exp_ev);
    int ev0, t_stable, t_rel, lat, rel;
    logic [15:0] kmask;
    logic [3:0]  code_before;
    kmask = 16'h0;
    kmask[r*4+c] = 1'b1;
    if (r2 >= 0) kmask[r2*4+c] = 1'b1;
    ev0 = ev_count;
    code_before = key_code;
    repeat (pb) begin
      pressed = kmask;
      step(bl);
      pressed = 16'h0;
      step(bl);
    end
    pressed = kmask;
    t_stable = cyc;
    step(hold);
    check_val("held_during_hold", {31'd0, key_held}, {31'd0, exp_ev});
    repeat (rb) begin
      pressed = 16'h0;
      step($urandom_range(1, 2));
      pressed = kmask;
      step(1);
    end
    pressed = 16'h0;
    t_rel = cyc;
    step(DEBOUNCE_CYC + 20);
    check_val("event_count", ev_count - ev0, exp_ev ? 1 : 0);
    if (exp_ev && ev_count > ev0) begin
      check_val("event_code", {28'd0, ev_codes[ev0]}, {28'd0, KMAP[r*4+c]});
      lat = ev_times[ev0] - t_stable;
      check_val("press_latency_in_range",
                {31'd0, (lat >= DEBOUNCE_CYC + 2) && (lat <= 2 + 4*SCAN_DIV + DEBOUNCE_CYC + 4)}, 1);
      rel = fall_time - t_rel;
      check_val("release_latency_in_range",
                {31'd0, (rel >= DEBOUNCE_CYC + 1) && (rel <= DEBOUNCE_CYC + 6)}, 1);
    end
    check_val("held_after_release", {31'd0, key_held}, 0);
    check_val("code_after_press", {28'd0, key_code},
              {28'd0, exp_ev ? KMAP[r*4+c] : code_before});
  endtask

  logic [3:0] samples [64];

  initial begin
    int ev0, guard, ntrans, run_len, idx, r, c, r2;

    // Reset values
    reset = 1'b0;
    step(3);
    check_val("rst_shift_col", {28'd0, shift_col}, 32'hE);
    check_val("rst_key_code",  {28'd0, key_code},  0);
    check_val("rst_key_valid", {31'd0, key_valid}, 0);
    check_val("rst_key_held",  {31'd0, key_held},  0);
    reset = 1'b1;

    // Idle scanning: column order and dwell length
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      samples[i] = shift_col;
    end
    ntrans = 0;
    run_len = 1;
    for (int i = 1; i < 64; i++) begin
      if (samples[i] != samples[i-1]) begin
        idx = 0;
        for (int k = 0; k < 4; k++) if (COLS[k] == samples[i-1]) idx = k;
        check_val("col_successor", {28'd0, samples[i]}, {28'd0, COLS[(idx+1)%4]});
        if (ntrans > 0) check_val("col_dwell", run_len, SCAN_DIV);
        ntrans++;
        run_len = 1;
      end else begin
        run_len++;
      end
    end
    check_val("col_steps_in_range", {31'd0, (ntrans >= 15) && (ntrans <= 16)}, 1);
    check_val("idle_no_event", ev_count, 0);
    check_val("idle_key_code", {28'd0, key_code}, 0);

    // r1,c2 long hold -> '6'
    do_press(1, 2, -1, 0, 0, HOLD_MAX, 0, 1'b1);
    // r3,c2 with three 2-cycle bounces -> OK key
    do_press(3, 2, -1, 3, 2, 40, 0, 1'b1);
    // two keys in column 0 (rows 1100) -> rejected
    do_press(0, 0, 1, 0, 0, 40, 0, 1'b0);

    // Reset pulsed mid-debounce with r0,c0 held
    guard = 0;
    while (shift_col != 4'hD && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    pressed = 16'h0001;
    while (shift_col != 4'hE && guard < 80) begin
      @(negedge clk);
      guard++;
    end
    check_val("col0_reached", {28'd0, shift_col}, 32'hE);
    ev0 = ev_count;
    step(SCAN_DIV + 3);
    check_val("no_event_before_reset", ev_count - ev0, 0);
    check_val("col_frozen_in_debounce", {28'd0, shift_col}, 32'hE);
    reset = 1'b0;
    step(2);
    check_val("midrst_shift_col", {28'd0, shift_col}, 32'hE);
    check_val("midrst_key_code",  {28'd0, key_code},  0);
    check_val("midrst_key_valid", {31'd0, key_valid}, 0);
    check_val("midrst_key_held",  {31'd0, key_held},  0);
    step(1);
    reset = 1'b1;
    step(40);
    check_val("post_reset_event_count", ev_count - ev0, 1);
    if (ev_count > ev0) check_val("post_reset_code", {28'd0, ev_codes[ev0]}, 32'h1);
    pressed = 16'h0;
    step(DEBOUNCE_CYC + 20);
    check_val("post_reset_released", {31'd0, key_held}, 0);

    // Randomized presses
    for (int n = 0; n < 20; n++) begin
      step($urandom_range(5, 40));
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      r2 = -1;
      if ($urandom_range(0, 5) == 0) r2 = (r + $urandom_range(1, 3)) % 4;
      do_press(r, c, r2, $urandom_range(0, 3), $urandom_range(1, 3),
               $urandom_range(34, HOLD_MAX), $urandom_range(0, 3), (r2 < 0));
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    // Auto-repeat: hold r0,c3 for 130 cycles past acceptance
    begin
      int t_acc;
      int exp_off[$];
      step(10);
      ev0 = ev_count;
      pressed = 16'h0008;
      guard = 0;
      while (ev_count == ev0 && guard < 60) begin
        @(negedge clk);
        guard++;
      end
      check_val("rep_first_event_seen", {31'd0, ev_count > ev0}, 1);
      t_acc = (ev_count > ev0) ? ev_times[ev0] : cyc;
      step(130);
      pressed = 16'h0;
      step(DEBOUNCE_CYC + 20);
      exp_off.push_back(0);
      for (int t = REPEAT_DELAY; t < 130; t += REPEAT_CYC) exp_off.push_back(t);
      check_val("rep_event_count", ev_count - ev0, exp_off.size());
      for (int k = 0; k < exp_off.size(); k++) begin
        if (ev0 + k < ev_count) begin
          check_val("rep_offset", ev_times[ev0+k] - t_acc, exp_off[k]);
          check_val("rep_code", {28'd0, ev_codes[ev0+k]}, 32'hA);
        end
      end
    end
`endif

    check_val("key_valid_never_back_to_back", kv_consec, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
